shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter: STEP_MAX, default 4, maximum 5-bit groups shifted per cycle; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_data  input  50  operand to shift right.
REQ-007 req_amt  input  4  total shift in 5-bit groups; legal 0..10.
REQ-008 req_fill  input  5  group value inserted at the MSB end on every step.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  50  shifted result.
REQ-012 rsp_err  output  1  request had req_amt > 10; qualified by rsp_valid.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, SHIFT and DONE, held in one registered state variable.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-016 On accept, data_reg SHALL load req_data, fill_reg SHALL load req_fill, rem SHALL load req_amt, and rsp_err SHALL load (req_amt > 10).
REQ-017 From accept: req_amt > 10 or req_amt = 0 SHALL go to DONE with data_reg = req_data; otherwise SHALL go to SHIFT.
REQ-018 In SHIFT, each edge SHALL apply step = min(rem, STEP_MAX), set data_reg = (data_reg >> 5*step) with the top step groups each = fill_reg, and set rem = rem - step.
REQ-019 SHIFT SHALL go to DONE on the edge where rem - step = 0; number of SHIFT edges = ceil(req_amt / STEP_MAX).
REQ-020 Shifter datapath SHALL never receive a per-step amount above 4 groups; any step outside 1..4 is a design error.
REQ-021 req_amt = 10 SHALL produce rsp_data with all ten groups equal to req_fill.
REQ-022 In DONE, rsp_valid SHALL be 1 and rsp_data SHALL equal data_reg; rsp_data and rsp_err SHALL hold stable while rsp_ready = 0.
REQ-023 DONE with rsp_ready = 1 on an edge SHALL go to IDLE; a new request SHALL NOT be accepted on that same edge.
REQ-024 req_valid, req_data, req_amt and req_fill SHALL be ignored outside IDLE; accepted values SHALL NOT be affected by later input changes.
REQ-025 Latency from accept edge to rsp_valid = 1: 1 edge for amt 0 or amt > 10, else 1 + ceil(amt/STEP_MAX) edges.
REQ-026 rsp_valid SHALL be 0 in IDLE and SHIFT; rsp_data outside DONE is don't-care but SHALL equal data_reg.

Reset
REQ-027 rst = 1 SHALL force, immediately and without a clock edge: state = IDLE, data_reg = 0, fill_reg = 0, rem = 0, rsp_err = 0.
REQ-028 Reset output values SHALL be: req_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 0.
REQ-029 Reset asserted in SHIFT or DONE SHALL abort the operation and discard the pending result; no rsp_valid SHALL follow.
REQ-030 After rst deasserts, the first request SHALL be acceptable on the first rising edge.

Verification
REQ-031 Shift in 3 steps: req_data = bit 49 set only, amt = 9, fill = 0, rsp_ready = 1 -> 3 SHIFT edges, rsp_valid after the 4th edge, rsp_data = 50'h10, rsp_err = 0.
REQ-032 Full fill: any req_data, amt = 10, fill = 5'b10101 -> every 5-bit group of rsp_data = 10101, 3 SHIFT edges.
REQ-033 Zero shift and error: amt = 0 -> rsp_data = req_data, rsp_err = 0, rsp_valid after 1 edge; amt = 11 -> rsp_data = req_data, rsp_err = 1, rsp_valid after 1 edge.
REQ-034 Backpressure: amt = 4 with rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready = 0, second req_valid ignored; release -> IDLE on the next edge.
REQ-035 Reset mid-shift: amt = 8, assert rst after the first SHIFT edge -> outputs equal reset values immediately, no rsp_valid; a new amt = 1 request then completes normally.
REQ-036 Random compare: random data, amt 0..15 and fill against a reference model of (data >> 5*amt) with fill groups; also run STEP_MAX = 1 to check latency = 1 + amt.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between a requester and the group-shift sequencer.
// The requester owns the request fields and rsp_ready; the controller owns the rest.
interface shift_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [49:0] req_data;
  logic [3:0]  req_amt;
  logic [4:0]  req_fill;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [49:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_data, req_amt, req_fill, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_data, req_amt, req_fill, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle right shifter of ten 5-bit groups: shifts up to STEP_MAX groups
// per cycle, inserting a fill group at the top, and holds the result until taken.
module shift_seq_ctrl #(
  parameter int STEP_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  shift_seq_ctrl_if.slave bus
);

  localparam int         GW      = 5;
  localparam logic [3:0] AMT_MAX = 4'd10;
  localparam logic [3:0] STEP_L  = 4'(STEP_MAX);

  generate
    if (STEP_MAX < 1 || STEP_MAX > 4) begin : g_bad_step
      $error("shift_seq_ctrl: STEP_MAX must be in 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [49:0] data_q,  data_d;
  logic [4:0]  fill_q,  fill_d;
  logic [3:0]  rem_q,   rem_d;
  logic        err_q,   err_d;

  logic [3:0]  step;
  logic [49:0] shifted;
  logic [49:0] shift_opts [1:4];

  assign step = (rem_q > STEP_L) ? STEP_L : rem_q;

  // One fixed-distance shifter per legal step size; the step picks among them.
  genvar gi;
  generate
    for (gi = 1; gi <= 4; gi++) begin : g_shift
      assign shift_opts[gi] = {{gi{fill_q}}, data_q[49:GW*gi]};
    end
  endgenerate

  always_comb begin
    shifted = data_q;
    case (step)
      4'd1:    shifted = shift_opts[1];
      4'd2:    shifted = shift_opts[2];
      4'd3:    shifted = shift_opts[3];
      4'd4:    shifted = shift_opts[4];
      default: shifted = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          data_d = bus.req_data;
          fill_d = bus.req_fill;
          rem_d  = bus.req_amt;
          err_d  = (bus.req_amt > AMT_MAX);
          if (bus.req_amt > AMT_MAX || bus.req_amt == 4'd0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - step;
        if (rem_q <= STEP_L) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Leaving DONE always passes through IDLE, so no accept on this edge.
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == SHIFT) begin
      assert (step >= 4'd1 && step <= 4'd4);
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench: a STEP_MAX=4 and a STEP_MAX=1 instance driven with table,
// hand-written and random requests, compared against a whole-shift reference model.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst;

  shift_seq_ctrl_if bus4 ();
  shift_seq_ctrl_if bus1 ();

  shift_seq_ctrl #(.STEP_MAX(4)) dut  (.clk(clk), .rst(rst), .bus(bus4));
  shift_seq_ctrl #(.STEP_MAX(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole shift in one go: drop amt low groups, fill the top amt groups.
  function automatic logic [49:0] ref_shift(input logic [49:0] d, input int amt,
                                            input logic [4:0] f);
    logic [49:0] r;
    if (amt > 10) return d;
    r = d >> (5 * amt);
    for (int g = 10 - amt; g < 10; g++) r[5*g +: 5] = f;
    return r;
  endfunction

  function automatic int ref_lat(input int amt, input int smax);
    if (amt == 0 || amt > 10) return 1;
    return 1 + (amt + smax - 1) / smax;
  endfunction

  typedef struct {
    logic [49:0] data;
    logic [3:0]  amt;
    logic [4:0]  fill;
    logic [49:0] exp_data;
    logic        exp_err;
    int          lat4;
    int          lat1;
  } vec_t;

  vec_t vecs [8];

  // Issues one request to both instances and checks both responses.
  task automatic run_txn(input string nm, input logic [49:0] d, input logic [3:0] a,
                         input logic [4:0] f, input logic [49:0] ed, input logic ee,
                         input int el4, input int el1);
    int lat4 = -1;
    int lat1 = -1;
    logic got4 = 1'b0;
    logic got1 = 1'b0;
    logic [49:0] rd4 = '0;
    logic [49:0] rd1 = '0;
    logic re4 = 1'b0;
    logic re1 = 1'b0;
    chk({nm, " req_ready4"}, 64'(bus4.req_ready), 64'(1));
    chk({nm, " req_ready1"}, 64'(bus1.req_ready), 64'(1));
    bus4.req_valid = 1'b1; bus4.req_data = d; bus4.req_amt = a; bus4.req_fill = f;
    bus1.req_valid = 1'b1; bus1.req_data = d; bus1.req_amt = a; bus1.req_fill = f;
    bus4.rsp_ready = 1'b1; bus1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.req_valid = 1'b0; bus4.req_data = ~d; bus4.req_amt = a + 4'd1; bus4.req_fill = ~f;
    bus1.req_valid = 1'b0; bus1.req_data = ~d; bus1.req_amt = a + 4'd1; bus1.req_fill = ~f;
    chk({nm, " busy4"}, 64'(bus4.busy), 64'(1));
    for (int n = 1; n <= 40 && !(got4 && got1); n++) begin
      if (!got4 && bus4.rsp_valid) begin
        got4 = 1'b1; lat4 = n; rd4 = bus4.rsp_data; re4 = bus4.rsp_err;
      end
      if (!got1 && bus1.rsp_valid) begin
        got1 = 1'b1; lat1 = n; rd1 = bus1.rsp_data; re1 = bus1.rsp_err;
      end
      if (!(got4 && got1)) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk({nm, " data4"}, 64'(rd4), 64'(ed));
    chk({nm, " err4"},  64'(re4), 64'(ee));
    chk({nm, " lat4"},  64'(lat4), 64'(el4));
    chk({nm, " data1"}, 64'(rd1), 64'(ed));
    chk({nm, " err1"},  64'(re1), 64'(ee));
    chk({nm, " lat1"},  64'(lat1), 64'(el1));
    $display("txn %s data=%h amt=%0d fill=%h -> rsp4=%h err4=%0b lat4=%0d lat1=%0d",
             nm, d, a, f, rd4, re4, lat4, lat1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " req_ready"}, 64'(bus4.req_ready), 64'(1));
    chk({nm, " rsp_valid"}, 64'(bus4.rsp_valid), 64'(0));
    chk({nm, " rsp_data"},  64'(bus4.rsp_data),  64'(0));
    chk({nm, " rsp_err"},   64'(bus4.rsp_err),   64'(0));
    chk({nm, " busy"},      64'(bus4.busy),      64'(0));
  endtask

  task automatic backpressure();
    logic [49:0] d = 50'h1_5A5A_3C3C_0F0F;
    logic [49:0] nd = 50'h0_0DEA_DBEE_F123;
    logic [49:0] ed;
    logic got = 1'b0;
    ed = ref_shift(d, 4, 5'h0A);
    bus4.req_valid = 1'b1; bus4.req_data = d; bus4.req_amt = 4'd4; bus4.req_fill = 5'h0A;
    bus4.rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus4.req_valid = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (bus4.rsp_valid) got = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("bp done", 64'(got), 64'(1));
    for (int c = 0; c < 5; c++) begin
      bus4.req_valid = 1'b1; bus4.req_data = 50'($urandom); bus4.req_amt = 4'd0;
      @(posedge clk);
      @(negedge clk);
      chk("bp rsp_valid", 64'(bus4.rsp_valid), 64'(1));
      chk("bp rsp_data",  64'(bus4.rsp_data),  64'(ed));
      chk("bp rsp_err",   64'(bus4.rsp_err),   64'(0));
      chk("bp req_ready", 64'(bus4.req_ready), 64'(0));
    end
    bus4.rsp_ready = 1'b1;
    bus4.req_data = nd; bus4.req_amt = 4'd0; bus4.req_fill = 5'h00;
    @(posedge clk);
    @(negedge clk);
    chk("bp release rsp_valid", 64'(bus4.rsp_valid), 64'(0));
    chk("bp release req_ready", 64'(bus4.req_ready), 64'(1));
    chk("bp release busy",      64'(bus4.busy),      64'(0));
    @(posedge clk);
    @(negedge clk);
    bus4.req_valid = 1'b0;
    chk("bp next rsp_valid", 64'(bus4.rsp_valid), 64'(1));
    chk("bp next rsp_data",  64'(bus4.rsp_data),  64'(nd));
    $display("txn backpressure data=%h amt=4 -> held %h, follow-up %h", d, ed, nd);
    @(posedge clk);
    @(negedge clk);
    chk("bp final busy", 64'(bus4.busy), 64'(0));
  endtask

  task automatic reset_mid_shift();
    logic [49:0] d = 50'h2_7777_8888_9999;
    bus4.req_valid = 1'b1; bus4.req_data = d; bus4.req_amt = 4'd8; bus4.req_fill = 5'h13;
    bus4.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst mid");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rst no rsp_valid", 64'(bus4.rsp_valid), 64'(0));
      @(posedge clk);
      @(negedge clk);
    end
    $display("txn reset_mid_shift data=%h amt=8 aborted", d);
    run_txn("after_rst", d, 4'd1, 5'h07, ref_shift(d, 1, 5'h07), 1'b0, 2, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    logic [49:0] d;
    logic [3:0]  a;
    logic [4:0]  f;

    vecs[0] = '{50'h2_0000_0000_0000, 4'd9,  5'h00, 50'h10,               1'b0, 4, 10};
    vecs[1] = '{50'h1234_5678_9ABC,   4'd10, 5'h15, {10{5'b10101}},       1'b0, 4, 11};
    vecs[2] = '{50'h2_AAAA_5555_1234, 4'd0,  5'h1F, 50'h2_AAAA_5555_1234, 1'b0, 1, 1};
    vecs[3] = '{50'h1_2345_6789_ABCD, 4'd11, 5'h03, 50'h1_2345_6789_ABCD, 1'b1, 1, 1};
    vecs[4] = '{50'h3_FFFF_FFFF_FFFF, 4'd4,  5'h00, 50'h3FFF_FFFF,        1'b0, 2, 5};
    vecs[5] = '{50'h0,                4'd5,  5'h1F, 50'h3FFFFFE000000,    1'b0, 3, 6};
    vecs[6] = '{50'h1,                4'd15, 5'h1F, 50'h1,                1'b1, 1, 1};
    vecs[7] = '{50'h2_0000_0000_0001, 4'd1,  5'h01, 50'h3000_0000_0000,   1'b0, 2, 2};

    clk = 1'b0;
    rst = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_data = '0; bus4.req_amt = '0; bus4.req_fill = '0;
    bus4.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_data = '0; bus1.req_amt = '0; bus1.req_fill = '0;
    bus1.rsp_ready = 1'b1;
    #2;
    check_reset_outputs("reset");
    chk("reset req_ready1", 64'(bus1.req_ready), 64'(1));
    chk("reset rsp_valid1", 64'(bus1.rsp_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt, vecs[i].fill,
              vecs[i].exp_data, vecs[i].exp_err, vecs[i].lat4, vecs[i].lat1);
    end

    backpressure();
    reset_mid_shift();

    for (int i = 0; i < 40; i++) begin
      r64 = {$urandom(), $urandom()};
      d = r64[49:0];
      a = 4'($urandom_range(0, 15));
      f = 5'($urandom());
      run_txn($sformatf("rand%0d", i), d, a, f, ref_shift(d, int'(a), f),
              (a > 4'd10), ref_lat(int'(a), 4), ref_lat(int'(a), 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
